// File: rtl/cook_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cook_pkg
//  Description : Shared state encodings, quick-start digits and keypad helpers
//                for the microwave cook-cycle sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cook_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENTRY  = 3'd1,
        ST_COOK   = 3'd2,
        ST_PAUSED = 3'd3,
        ST_DONE   = 3'd4,
        ST_QLOAD  = 3'd5
    } state_t;

    // Quick-start entry 3,0 (30 s); first digit in the upper nibble.
    localparam logic [7:0] QUICK_DIGITS = {4'd3, 4'd0};

    function automatic logic is_onehot(input logic [9:0] keys);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 10; i++) begin
            n = n + {3'b000, keys[i]};
        end
        return (n == 4'd1);
    endfunction

    function automatic logic [3:0] key_encode(input logic [9:0] keys);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) d = 4'(i);
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tick_divider
//  Description : Counts 0..CLK_HZ-1 while run is high and pulses tick on wrap.
//                restart forces the count to zero and suppresses the tick.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int CLK_HZ = 100
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic restart,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] C_LAST = W'(CLK_HZ - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset || restart) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = run & ~restart & (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/cook_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cook_sequencer
//  Description : Microwave cook-cycle controller: keypad digit loads, 1 Hz
//                count tick, magnetron enable and done beeper.
//                Optional quick start (3,0 then cook) when QUICK_START_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module cook_sequencer
    import cook_pkg::*;
#(
    parameter int CLK_HZ     = 100,
    parameter int BEEP_SECS  = 3,
    parameter int MAX_DIGITS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       clearn,
    input  logic       door_closed,
    input  logic       timer_zero,
    output logic [3:0] digit_data,
    output logic       digit_loadn,
    output logic       count_tick,
    output logic       cnt_clear,
    output logic       mag_on,
    output logic       beep,
    output logic [2:0] state_code
);

    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam int BW = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;
    localparam logic [CW-1:0] C_MAX_CNT   = CW'(MAX_DIGITS);
    localparam logic [BW-1:0] C_BEEP_LAST = BW'(BEEP_SECS - 1);

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [BW-1:0] r_beep_ticks;
    logic [2:0]    r_btn_prev;
    logic [2:0]    r_btn_ev;
    logic [9:0]    r_key_prev;
    logic          r_key_ev;
    logic [3:0]    r_key_digit;
`ifdef QUICK_START_EN
    logic [1:0]    r_qstep;
`endif

    logic w_start, w_stop, w_clear, w_any_event;
    logic w_cook_to_done, w_div_run, w_div_restart, w_div_tick;

    assign w_start     = r_btn_ev[2];
    assign w_stop      = r_btn_ev[1];
    assign w_clear     = r_btn_ev[0];
    assign w_any_event = (|r_btn_ev) | r_key_ev;

    // Button falls and fresh single keys become one-cycle events a cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_prev  <= 3'b111;
            r_btn_ev    <= 3'b000;
            r_key_prev  <= '0;
            r_key_ev    <= 1'b0;
            r_key_digit <= 4'd0;
        end else begin
            r_btn_prev  <= {startn, stopn, clearn};
            r_btn_ev    <= r_btn_prev & ~{startn, stopn, clearn};
            r_key_prev  <= keypad;
            r_key_ev    <= (r_key_prev == 10'd0) && is_onehot(keypad);
            r_key_digit <= key_encode(keypad);
        end
    end

    // Divider is zeroed outside cooking and on the edge into DONE; held while paused.
    assign w_cook_to_done = (r_state == ST_COOK) && timer_zero && !w_clear
                            && !w_stop && door_closed;
    assign w_div_run      = (r_state == ST_COOK) || (r_state == ST_DONE);
    assign w_div_restart  = !((r_state == ST_COOK) || (r_state == ST_PAUSED)
                              || (r_state == ST_DONE)) || w_cook_to_done;

    tick_divider #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_divider (
        .clock   (clock),
        .reset   (reset),
        .run     (w_div_run),
        .restart (w_div_restart),
        .tick    (w_div_tick)
    );

    assign count_tick = w_div_tick && (r_state == ST_COOK);
    assign state_code = r_state;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_beep_ticks <= '0;
            digit_data   <= 4'd0;
            digit_loadn  <= 1'b1;
            cnt_clear    <= 1'b0;
            mag_on       <= 1'b0;
            beep         <= 1'b0;
`ifdef QUICK_START_EN
            r_qstep      <= 2'd0;
`endif
        end else begin
            digit_loadn <= 1'b1;
            cnt_clear   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    mag_on <= 1'b0;
                    beep   <= 1'b0;
`ifdef QUICK_START_EN
                    if (w_start && door_closed) begin
                        r_state     <= ST_QLOAD;
                        r_qstep     <= 2'd0;
                        digit_data  <= QUICK_DIGITS[7:4];
                        digit_loadn <= 1'b0;
                    end else
`endif
                    if (r_key_ev) begin
                        r_state     <= ST_ENTRY;
                        r_count     <= CW'(1);
                        digit_data  <= r_key_digit;
                        digit_loadn <= 1'b0;
                    end
                end
                ST_ENTRY: begin
                    if (w_clear) begin
                        cnt_clear <= 1'b1;
                        r_count   <= '0;
                        r_state   <= ST_IDLE;
                    end else if (w_start) begin
                        if (door_closed && !timer_zero) begin
                            r_state <= ST_COOK;
                            mag_on  <= 1'b1;
                        end
                    end else if (r_key_ev && (r_count < C_MAX_CNT)) begin
                        r_count     <= r_count + 1'b1;
                        digit_data  <= r_key_digit;
                        digit_loadn <= 1'b0;
                    end
                end
                ST_COOK: begin
                    if (w_clear) begin
                        cnt_clear <= 1'b1;
                        r_count   <= '0;
                        mag_on    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end else if (w_stop || !door_closed) begin
                        mag_on  <= 1'b0;
                        r_state <= ST_PAUSED;
                    end else if (timer_zero) begin
                        mag_on       <= 1'b0;
                        beep         <= 1'b1;
                        r_beep_ticks <= '0;
                        r_state      <= ST_DONE;
                    end
                end
                ST_PAUSED: begin
                    if (w_clear || w_stop) begin
                        cnt_clear <= 1'b1;
                        r_count   <= '0;
                        r_state   <= ST_IDLE;
                    end else if (w_start && door_closed) begin
                        mag_on  <= 1'b1;
                        r_state <= ST_COOK;
                    end
                end
                ST_DONE: begin
                    if (w_any_event) begin
                        beep    <= 1'b0;
                        r_count <= '0;
                        r_state <= ST_IDLE;
                    end else if (w_div_tick) begin
                        if (r_beep_ticks == C_BEEP_LAST) begin
                            beep    <= 1'b0;
                            r_count <= '0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_beep_ticks <= r_beep_ticks + 1'b1;
                        end
                    end
                end
`ifdef QUICK_START_EN
                ST_QLOAD: begin
                    // Strobe 3, one idle cycle, strobe 0, then cook.
                    r_qstep <= r_qstep + 2'd1;
                    if (r_qstep == 2'd1) begin
                        digit_data  <= QUICK_DIGITS[3:0];
                        digit_loadn <= 1'b0;
                    end else if (r_qstep == 2'd2) begin
                        mag_on  <= 1'b1;
                        r_state <= ST_COOK;
                    end
                end
`endif
                default: begin
                    mag_on  <= 1'b0;
                    beep    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cook_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cook_sequencer
//  Description : Scoreboard bench for cook_sequencer: digit strobes, tick
//                spacing in magnetron-on time, pause/resume, beep and clears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cook_sequencer;

    localparam int CLK_HZ     = 100;
    localparam int BEEP_SECS  = 3;
    localparam int MAX_DIGITS = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] keypad = '0;
    logic       startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
    logic       door_closed = 1'b1, timer_zero = 1'b0;
    logic [3:0] digit_data;
    logic       digit_loadn, count_tick, cnt_clear, mag_on, beep;
    logic [2:0] state_code;

    cook_sequencer #(
        .CLK_HZ     (CLK_HZ),
        .BEEP_SECS  (BEEP_SECS),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .clearn      (clearn),
        .door_closed (door_closed),
        .timer_zero  (timer_zero),
        .digit_data  (digit_data),
        .digit_loadn (digit_loadn),
        .count_tick  (count_tick),
        .cnt_clear   (cnt_clear),
        .mag_on      (mag_on),
        .beep        (beep),
        .state_code  (state_code)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [3:0] sb_q[$];
    int on_cnt    = 0;
    int tick_seen = 0;
    int clr_seen  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic key(input int d, input bit strobe_expected);
        if (strobe_expected) sb_q.push_back(4'(d));
        keypad = 10'(1 << d);
        cycles(2);
        keypad = '0;
        cycles(3);
    endtask

    task automatic press(input bit s, input bit p, input bit c);
        startn = ~s;
        stopn  = ~p;
        clearn = ~c;
        cycles(2);
        startn = 1'b1;
        stopn  = 1'b1;
        clearn = 1'b1;
        cycles(3);
    endtask

    task automatic wait_ticks(input int n, input int budget);
        int t0;
        t0 = tick_seen;
        for (int i = 0; i < budget; i++) begin
            if (tick_seen >= t0 + n) break;
            cycles(1);
        end
        check("tick_count", 32'(tick_seen - t0), 32'(n));
    endtask

    // Monitor: strobes against the scoreboard, ticks against magnetron-on time.
    initial begin
        logic [3:0] exp_d;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (!digit_loadn) begin
                    check("strobe_expected", 32'(sb_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0) begin
                        exp_d = sb_q.pop_front();
                        check("digit_data", 32'(digit_data), 32'(exp_d));
                    end
                end
                if (cnt_clear) clr_seen++;
                if (mag_on) on_cnt++;
                if (count_tick) begin
                    check("tick_while_cooking", 32'(mag_on), 32'd1);
                    check("tick_period", 32'(on_cnt), 32'(CLK_HZ));
                    on_cnt = 0;
                    tick_seen++;
                end
                if (state_code == 3'd0 || state_code == 3'd1) on_cnt = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n;
        cycles(3);
        @(negedge clock);
        check("rst_state", 32'(state_code), 32'd0);
        check("rst_data", 32'(digit_data), 32'd0);
        check("rst_loadn", 32'(digit_loadn), 32'd1);
        check("rst_tick", 32'(count_tick), 32'd0);
        check("rst_clear", 32'(cnt_clear), 32'd0);
        check("rst_mag", 32'(mag_on), 32'd0);
        check("rst_beep", 32'(beep), 32'd0);
        cycles(1);
        reset = 1'b0;
        cycles(2);

        // Start in IDLE.
`ifdef QUICK_START_EN
        sb_q.push_back(4'd3);
        sb_q.push_back(4'd0);
        press(1'b1, 1'b0, 1'b0);
        cycles(3);
        check("quick_state", 32'(state_code), 32'd2);
        check("quick_mag", 32'(mag_on), 32'd1);
        press(1'b0, 1'b0, 1'b1);
        check("quick_clear_state", 32'(state_code), 32'd0);
`else
        press(1'b1, 1'b0, 1'b0);
        check("idle_start_state", 32'(state_code), 32'd0);
        check("idle_start_mag", 32'(mag_on), 32'd0);
`endif

        // Keys 1,3,0 then cook with ticks.
        key(1, 1'b1);
        key(3, 1'b1);
        key(0, 1'b1);
        check("entry_state", 32'(state_code), 32'd1);
        check("sb_after_keys", 32'(sb_q.size()), 32'd0);
        press(1'b1, 1'b0, 1'b0);
        check("cook_state", 32'(state_code), 32'd2);
        check("cook_mag", 32'(mag_on), 32'd1);
        wait_ticks(2, 3 * CLK_HZ);

        // Door opens mid-tick, closes, start resumes from the held divider.
        cycles(50);
        door_closed = 1'b0;
        cycles(3);
        check("pause_state", 32'(state_code), 32'd3);
        check("pause_mag", 32'(mag_on), 32'd0);
        c0 = tick_seen;
        cycles(40);
        door_closed = 1'b1;
        cycles(2);
        check("pause_no_tick", 32'(tick_seen - c0), 32'd0);
        check("door_close_stays", 32'(state_code), 32'd3);
        press(1'b1, 1'b0, 1'b0);
        check("resume_mag", 32'(mag_on), 32'd1);
        wait_ticks(1, CLK_HZ);

        // Timer reaches zero: beep for BEEP_SECS seconds.
        cycles(30);
        timer_zero = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("done_mag", 32'(mag_on), 32'd0);
        check("done_beep", 32'(beep), 32'd1);
        check("done_state", 32'(state_code), 32'd4);
        n = 1;
        for (int i = 0; i < 2 * BEEP_SECS * CLK_HZ; i++) begin
            @(negedge clock);
            if (!beep) break;
            n++;
        end
        check("beep_cycles", 32'(n), 32'(BEEP_SECS * CLK_HZ));
        check("after_beep_state", 32'(state_code), 32'd0);
        cycles(1);
        timer_zero = 1'b0;

        // Digit limit, multi-hot, start with door open, clear in ENTRY.
        for (int d = 1; d <= 5; d++) key(d, d <= MAX_DIGITS);
        check("limit_state", 32'(state_code), 32'd1);
        keypad = 10'b0000000110;
        cycles(2);
        keypad = '0;
        cycles(3);
        check("sb_after_limit", 32'(sb_q.size()), 32'd0);
        door_closed = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        check("start_door_open", 32'(state_code), 32'd1);
        door_closed = 1'b1;
        c0 = clr_seen;
        press(1'b0, 1'b0, 1'b1);
        check("entry_clear_pulse", 32'(clr_seen - c0), 32'd1);
        check("entry_clear_state", 32'(state_code), 32'd0);

        // Stop and clear together while cooking.
        key(2, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        check("cook2_state", 32'(state_code), 32'd2);
        c0 = clr_seen;
        press(1'b0, 1'b1, 1'b1);
        check("stopclr_pulse", 32'(clr_seen - c0), 32'd1);
        check("stopclr_state", 32'(state_code), 32'd0);
        check("stopclr_mag", 32'(mag_on), 32'd0);

        // Start refused at 00:00, then a key ends the beep without loading.
        key(7, 1'b1);
        timer_zero = 1'b1;
        press(1'b1, 1'b0, 1'b0);
        check("start_tz_state", 32'(state_code), 32'd1);
        timer_zero = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        check("cook3_state", 32'(state_code), 32'd2);
        timer_zero = 1'b1;
        cycles(3);
        check("beep3_on", 32'(beep), 32'd1);
        key(9, 1'b0);
        check("key_end_beep", 32'(beep), 32'd0);
        check("key_end_state", 32'(state_code), 32'd0);
        timer_zero = 1'b0;
        cycles(5);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cook_sequencer.md
Name: cook_sequencer

Overview:
Top-level cook-cycle controller for the microwave.
- Turns keypad presses into digit loads for the minutes/seconds counter.
- Generates the 1 Hz count tick.
- Drives mag_on from start/stop/clear/door events and sounds a done beeper.
- Sits between the front-panel inputs and the counter/decoder datapath.

Parameters:
- CLK_HZ, 100, clock cycles per count tick (1 s).
- BEEP_SECS, 3, beeper duration in ticks after timer reaches zero.
- MAX_DIGITS, 4, maximum digits accepted per entry (mm:ss).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- keypad  in  10  one-hot key levels, bit n = digit n.
- startn  in  1  start button, active-low level.
- stopn  in  1  stop button, active-low level.
- clearn  in  1  clear button, active-low level.
- door_closed  in  1  1 = door closed.
- timer_zero  in  1  counter reports 00:00.
- digit_data  out  4  BCD digit to shift into counter.
- digit_loadn  out  1  active-low, one-cycle digit load strobe.
- count_tick  out  1  one-cycle decrement pulse to counter.
- cnt_clear  out  1  one-cycle counter clear pulse.
- mag_on  out  1  magnetron enable.
- beep  out  1  done alarm.
- state_code  out  3  current FSM state, for debug/display.

Behaviour:
- Reset values:
  - State IDLE; digit count 0; divider 0.
  - digit_data=0, digit_loadn=1, count_tick=0, cnt_clear=0, mag_on=0, beep=0.
- Button events:
  - startn, stopn, clearn are edge-detected on the falling edge, registered one cycle; event valid the cycle after the edge.
  - Held buttons produce one event only.
- Key events:
  - Registered only when keypad goes from all-zero to exactly one bit set.
  - Multi-hot or still-held keypad produces no event.
  - On a key event: digit_data = bit index, digit_loadn=0 for one cycle, next cycle back to 1.
- States (state_code): IDLE=0, ENTRY=1, COOK=2, PAUSED=3, DONE=4, QLOAD=5 (QLOAD exists only with QUICK_START_EN).
- Event priority in one cycle: clear > stop > door open > timer_zero > start > key.
- IDLE:
  - Key event -> load digit, count=1, go ENTRY.
  - Start -> ignored (without the optional feature).
- ENTRY:
  - Key event with count < MAX_DIGITS -> load digit, count++.
  - Key event with count == MAX_DIGITS -> ignored, no strobe.
  - Start with door_closed=1 and timer_zero=0 -> COOK, divider cleared.
  - Start with door open or timer_zero=1 -> stay ENTRY.
  - Clear -> cnt_clear pulse, count=0, go IDLE.
- COOK:
  - mag_on=1 registered, asserted from the first COOK cycle.
  - Divider counts 0..CLK_HZ-1; count_tick=1 for the cycle the divider wraps, first tick CLK_HZ cycles after entry.
  - Keys ignored.
  - timer_zero=1 -> DONE.
  - Stop or door_closed=0 -> PAUSED; divider value held.
  - Clear -> cnt_clear pulse, go IDLE.
- PAUSED:
  - mag_on=0, divider frozen.
  - Start with door_closed=1 -> COOK, divider resumes from held value.
  - Stop or clear -> cnt_clear pulse, count=0, go IDLE.
- DONE:
  - mag_on=0, beep=1, divider restarts at 0.
  - After BEEP_SECS ticks -> IDLE, beep=0, count=0.
  - Any button press or key event ends beep immediately -> IDLE; the key is not loaded.
- Reset mid-cook: mag_on drops to 0 on the next edge. Counter contents are not cleared by this block; cnt_clear is not pulsed on reset.
- The divider must be sized clog2(CLK_HZ); no wrap artefacts at CLK_HZ=1, where every cycle is a tick.

Optional Feature:
- Macro: QUICK_START_EN.
- Defined: start in IDLE with door_closed=1:
  - Go QLOAD; load digit 3, then digit 0 on consecutive strobes, one idle cycle between them.
  - Then enter COOK (30 s quick cook).
  - In ENTRY or PAUSED, start behaves as above.
- Undefined: QLOAD does not exist; start in IDLE is ignored.

Decomposition:
- Package cook_pkg:
  - state enum and state_code encodings.
  - QUICK_DIGITS constant {3,0}.
  - one-hot-to-BCD key encode function.
- One sub-module, tick_divider: parameter CLK_HZ; inputs clock, reset, run, restart; output tick.

Test Plan:
- Keys 1,3,0 then start, door closed -> three digit_loadn strobes with data 1,3,0; mag_on=1; count_tick every 100 cycles.
- Five keys 1..5 -> only four strobes (1,2,3,4); key 5 produces no strobe.
- Cooking, door opens at cycle 50 of a tick, then closes, then start -> mag_on=0 while paused; next tick 50 cycles after resume.
- Cooking, timer_zero asserted -> mag_on=0 next cycle; beep=1 for 300 cycles; then IDLE (state_code=0).
- Stop and clear pressed together while cooking -> cnt_clear pulse; IDLE; mag_on=0.
- QUICK_START_EN defined, start in IDLE -> strobes 3 then 0; COOK; mag_on=1. Undefined -> no response.
